// File: rtl/mmio_uart_tx_if.sv
// Data-memory-port bus as seen by the memory-mapped UART transmitter.
// The pipeline's memory stage is the master. ReadData is returned
// combinationally by the selected slave.
interface mmio_uart_tx_if;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  modport master (output MemWrite, Addr, WriteData, input ReadData);
  modport slave  (input MemWrite, Addr, WriteData, output ReadData);
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TX FIFO, baud divisor and framing FSM.
// Register window of 16 bytes at BASE: TXDATA, STATUS, BAUDDIV, reserved.
// Optional even-parity bit compiled in with `define MMIO_UART_PARITY_EN
// (11-bit frame); otherwise 8N1 (10-bit frame).
module mmio_uart_tx #(
  parameter logic [31:0] BASE    = 32'hFFFF_0000,
  parameter int unsigned DEPTH   = 8,
  parameter logic [15:0] DIV_RST = 16'd867
) (
  input  logic          clk,
  input  logic          reset,
  mmio_uart_tx_if.slave bus,
  output logic          tx,
  output logic          busy
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

`ifdef MMIO_UART_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t        state, state_n;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   cnt;
  logic [15:0]   baud, bcnt;
  logic [2:0]    bidx;
  logic [7:0]    shreg;
  logic          ovf;
  logic          pop, push, tick, tx_n;
`ifdef MMIO_UART_PARITY_EN
  logic          par;
`endif

  // Decode: word access only, byte offset bits are don't-care.
  logic       sel;
  logic [1:0] off;
  logic       wr_data, wr_stat, wr_baud, full, empty;
  logic       unused_bits;
  assign sel     = (bus.Addr[31:4] == BASE[31:4]);
  assign off     = bus.Addr[3:2];
  assign wr_data = bus.MemWrite & sel & (off == 2'd0);
  assign wr_stat = bus.MemWrite & sel & (off == 2'd1);
  assign wr_baud = bus.MemWrite & sel & (off == 2'd2);
  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign tick    = (bcnt == 16'd0);
  // A full FIFO still accepts a push when the framer pops at the same edge.
  assign push    = wr_data & (~full | pop);
  assign busy    = (state != S_IDLE) | ~empty;
  assign unused_bits = ^{bus.Addr[1:0], bus.WriteData[31:16]};

  // Load data: combinational, zero when the window is not selected.
  always_comb begin
    bus.ReadData = 32'd0;
    if (sel) begin
      case (off)
        2'd1:    bus.ReadData = {28'd0, ovf, busy, empty, full};
        2'd2:    bus.ReadData = {16'd0, baud};
        default: bus.ReadData = 32'd0;
      endcase
    end
  end

  // Framer next-state, pop request and next serial bit.
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    tx_n    = 1'b1;
    case (state)
      S_IDLE: begin
        tx_n = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          state_n = S_START;
        end
      end
      S_START: begin
        tx_n = 1'b0;
        if (tick) state_n = S_DATA;
      end
      S_DATA: begin
        tx_n = shreg[0];
        if (tick && bidx == 3'd7)
`ifdef MMIO_UART_PARITY_EN
          state_n = S_PARITY;
`else
          state_n = S_STOP;
`endif
      end
`ifdef MMIO_UART_PARITY_EN
      S_PARITY: begin
        tx_n = par;
        if (tick) state_n = S_STOP;
      end
`endif
      S_STOP: begin
        tx_n = 1'b1;
        if (tick) begin
          // Back-to-back frames: go straight to START with no idle bit.
          if (!empty) begin
            pop     = 1'b1;
            state_n = S_START;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= bus.WriteData[7:0];
  end

  // FIFO pointers/count, sticky overflow and baud divisor register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      ovf  <= 1'b0;
      baud <= DIV_RST;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
      // A rejected push in the same cycle as a clear leaves overflow set.
      if (wr_data && !push)               ovf <= 1'b1;
      else if (wr_stat && bus.WriteData[3]) ovf <= 1'b0;
      if (wr_baud) baud <= bus.WriteData[15:0];
    end
  end

  // Framer state, baud counter, bit index, shift register and registered tx.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      bcnt  <= 16'd0;
      bidx  <= 3'd0;
      shreg <= 8'd0;
      tx    <= 1'b1;
`ifdef MMIO_UART_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      state <= state_n;
      tx    <= tx_n;
      // Reload at every bit boundary so a new BAUDDIV applies from the next bit.
      if (pop || (state != S_IDLE && tick)) bcnt <= baud;
      else if (state != S_IDLE)             bcnt <= bcnt - 16'd1;
      if (pop) begin
        shreg <= mem[rptr];
        bidx  <= 3'd0;
`ifdef MMIO_UART_PARITY_EN
        par   <= ^mem[rptr];
`endif
      end else if (state == S_DATA && tick) begin
        shreg <= shreg >> 1;
        bidx  <= bidx + 3'd1;
      end
    end
  end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx. A serial receiver model decodes
// frames off tx and checks them against a queue of expected bytes; a second
// monitor checks register/pin observations queued by the stimulus.
`timescale 1ns/1ps
module tb_mmio_uart_tx;
  localparam logic [31:0] BASE = 32'hFFFF_0000;
`ifdef MMIO_UART_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tx, busy;
  mmio_uart_tx_if bus();

  mmio_uart_tx #(.BASE(BASE), .DEPTH(8), .DIV_RST(16'd867)) dut (
    .clk(clk), .reset(reset), .bus(bus), .tx(tx), .busy(busy));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cur_div = 867;
  logic [7:0]  exp_bytes[$];
  int          obs_sel_q[$];
  logic [31:0] obs_exp_q[$];
  string       obs_name_q[$];
  int obs_issued = 0;
  int obs_done = 0;
  bit mon_busy = 1'b0;

  task automatic score(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // Expected frame, bit 0 = start bit, transmitted LSB-first.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic [10:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = b;
`ifdef MMIO_UART_PARITY_EN
    f[9]   = ^b;
`endif
    return f;
  endfunction

  // Observation monitor: compares queued expectations against the DUT.
  int          o_sel;
  logic [31:0] o_exp, o_act;
  string       o_name;
  initial forever begin
    wait (obs_issued != obs_done);
    o_sel  = obs_sel_q.pop_front();
    o_exp  = obs_exp_q.pop_front();
    o_name = obs_name_q.pop_front();
    case (o_sel)
      0:       o_act = bus.ReadData;
      1:       o_act = {31'd0, tx};
      default: o_act = {31'd0, busy};
    endcase
    score(o_act === o_exp, o_name, o_act, o_exp);
    obs_done++;
  end

  // Serial receiver: every bit must hold for exactly cur_div+1 clocks.
  int          rx_p;
  bit          rx_abort, rx_stable;
  logic [10:0] rx_f, rx_ef;
  logic [7:0]  rx_b;
  initial forever begin
    @(negedge clk);
    if (reset && tx === 1'b0) begin
      mon_busy  = 1'b1;
      rx_p      = cur_div + 1;
      rx_abort  = 1'b0;
      rx_stable = 1'b1;
      rx_f      = '1;
      for (int b = 0; b < FB; b++) begin
        for (int j = 0; j < rx_p; j++) begin
          if (b != 0 || j != 0) @(negedge clk);
          if (!reset) rx_abort = 1'b1;
          if (j == 0) rx_f[b] = tx;
          else if (tx !== rx_f[b]) rx_stable = 1'b0;
        end
      end
      if (!rx_abort) begin
        if (exp_bytes.size() == 0) begin
          score(1'b0, "unexpected_frame", {21'd0, rx_f}, 32'd0);
        end else begin
          rx_b  = exp_bytes.pop_front();
          rx_ef = frame_of(rx_b);
          score(rx_f[FB-1:0] === rx_ef[FB-1:0], "frame", {21'd0, rx_f}, {21'd0, rx_ef});
          score(rx_stable, "bit_timing", {31'd0, rx_stable}, 32'd1);
        end
      end
      mon_busy = 1'b0;
    end
  end

  task automatic expect_now(input int sel, input logic [31:0] e, input string nm);
    obs_sel_q.push_back(sel);
    obs_exp_q.push_back(e);
    obs_name_q.push_back(nm);
    obs_issued++;
    wait (obs_done == obs_issued);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bus.MemWrite = 1'b1; bus.Addr = a; bus.WriteData = d;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    bus.MemWrite = 1'b0; bus.Addr = 32'd0; bus.WriteData = 32'd0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string nm);
    @(posedge clk); #1;
    bus.MemWrite = 1'b0; bus.Addr = a; bus.WriteData = 32'd0;
    @(negedge clk);
    expect_now(0, e, nm);
  endtask

  task automatic drain(input int budget, input string nm);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_bytes.size() == 0 && !busy && !mon_busy) break;
    end
    score(i < budget, nm, i, budget);
  endtask

  logic [21:0] bb_vec, bb_exp;
  logic [10:0] f0, f1;
  bit          found;

  initial begin
    bus.MemWrite = 1'b0; bus.Addr = 32'd0; bus.WriteData = 32'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Reset state.
    @(negedge clk);
    expect_now(1, 32'd1, "rst_tx");
    expect_now(2, 32'd0, "rst_busy");
    rd(BASE + 32'h4, 32'h2, "rst_status");
    rd(BASE + 32'h8, 32'd867, "rst_baud");

    // 0xA5 at BAUDDIV=3, with first-frame latency: tx falls after edge k+2.
    wr(BASE + 32'h8, 32'd3); cur_div = 3;
    exp_bytes.push_back(8'hA5);
    wr(BASE, 32'hA5);
    idle();
    @(negedge clk); expect_now(1, 32'd1, "lat_edge_k");
    @(negedge clk); expect_now(1, 32'd1, "lat_edge_k1");
    @(negedge clk); expect_now(1, 32'd0, "lat_edge_k2");
    drain(200, "drain_a5");

    // Reset mid-frame: 0x55 bit1 is on the line ten edges after the write.
    wr(BASE, 32'h55);
    idle();
    repeat (10) @(posedge clk);
    #1;
    expect_now(1, 32'd0, "pre_reset_tx");
    reset = 1'b0;
    #1;
    expect_now(1, 32'd1, "reset_mid_tx");
    expect_now(2, 32'd0, "reset_mid_busy");
    @(posedge clk); #1 reset = 1'b1; cur_div = 867;
    rd(BASE + 32'h4, 32'h2, "reset_mid_status");
    rd(BASE + 32'h8, 32'd867, "reset_mid_baud");
    repeat (60) @(posedge clk);

    // Overflow: the first byte is popped one edge after its write, so the
    // FIFO takes bytes 2..9 and the 10th back-to-back write is rejected.
    wr(BASE + 32'h8, 32'd100); cur_div = 100;
    for (int i = 0; i < 10; i++) begin
      wr(BASE, 32'h10 + i);
      if (i < 9) exp_bytes.push_back(8'(8'h10 + i));
    end
    rd(BASE + 32'h4, 32'hD, "status_overflow");
    rd(BASE, 32'h0, "txdata_reads_zero");
    wr(BASE + 32'h4, 32'h7);
    rd(BASE + 32'h4, 32'hD, "status_no_clear");
    wr(BASE + 32'h4, 32'h8);
    rd(BASE + 32'h4, 32'h5, "overflow_cleared");
    drain(12000, "drain_overflow");
    rd(BASE + 32'h4, 32'h2, "status_drained");

    // Back-to-back 0x00, 0xFF at one clock per bit: no idle gap.
    wr(BASE + 32'h8, 32'd0); cur_div = 0;
    exp_bytes.push_back(8'h00);
    exp_bytes.push_back(8'hFF);
    wr(BASE, 32'h00);
    wr(BASE, 32'hFF);
    idle();
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin found = 1'b1; break; end
    end
    score(found, "b2b_start_seen", {31'd0, found}, 32'd1);
    if (found) begin
      f0 = frame_of(8'h00);
      f1 = frame_of(8'hFF);
      bb_vec = '0;
      bb_exp = '0;
      for (int i = 0; i < FB; i++) begin
        bb_exp[i]      = f0[i];
        bb_exp[i + FB] = f1[i];
      end
      bb_vec[0] = tx;
      for (int i = 1; i < 2 * FB; i++) begin
        @(negedge clk);
        bb_vec[i] = tx;
        if (i == 2 * FB - 2) expect_now(2, 32'd1, "b2b_busy_last_stop");
      end
      score(bb_vec === bb_exp, "b2b_no_gap", {10'd0, bb_vec}, {10'd0, bb_exp});
      @(negedge clk);
      expect_now(2, 32'd0, "b2b_busy_dropped");
    end
    drain(100, "drain_b2b");

    // Window decode and BAUDDIV width.
    wr(BASE + 32'hC, 32'hFFFF_FFFF);
    rd(BASE + 32'hC, 32'h0, "reserved_reads_zero");
    rd(32'h1234_5678, 32'h0, "outside_reads_zero");
    wr(BASE + 32'h8, 32'hFFFF_0010);
    rd(BASE + 32'h8, 32'h0000_0010, "baud_upper_zero");
    rd(32'hFFFF_0018, 32'h0, "adjacent_reads_zero");
    wr(32'hFFFF_0010, 32'h41);
    rd(BASE + 32'h4, 32'h2, "outside_no_push");
    idle();
    repeat (5) @(posedge clk);
    score(exp_bytes.size() == 0, "no_pending_frames", exp_bytes.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
